// File: rtl/seg7_pkg.sv
// Shared types and the 7-segment encoder for the BCD score display.
package seg7_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g..a} pattern; anything outside 0..9 is blanked.
    function automatic logic [6:0] seg7_encode(input bcd_digit_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the score with ripple carry/borrow to the next cell.
module bcd_digit_cell
    import seg7_pkg::*;
(
    input  logic       CLK_50M,
    input  logic       RST,
    input  logic       inc_ci,
    input  logic       dec_bi,
    input  logic       clr,
    output bcd_digit_t digit,
    output logic       carry_o,
    output logic       borrow_o
);

    assign carry_o  = inc_ci & (digit == 4'd9);
    assign borrow_o = dec_bi & (digit == 4'd0);

    // inc_ci and dec_bi are never both set by the top level.
    always_ff @(posedge CLK_50M) begin
        if (RST || clr) begin
            digit <= '0;
        end else if (inc_ci) begin
            digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        end else if (dec_bi) begin
            digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_score_display.sv
// N-digit saturating BCD score with a multiplexed active-low 7-segment scan.
// Build option: LEADING_ZERO_BLANK_EN blanks zero digits above the most-significant nonzero one.
module bcd_score_display
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_CYCLES = 50000
)(
    input  logic                    CLK_50M,
    input  logic                    RST,
    input  logic                    inc_in,
    input  logic                    dec_in,
    input  logic                    clr_in,
    output logic [4*NUM_DIGITS-1:0] score_o,
    output logic                    ovf_o,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   sel
);

    localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic             inc_q;
    logic             dec_q;
    logic             ev_inc;
    logic             ev_dec;
    logic             all9;
    logic             all0;
    logic             ovf_set;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [NUM_DIGITS-1:0] shown;
    logic [NUM_DIGITS:0]   carry;
    logic [NUM_DIGITS:0]   borrow;
    bcd_digit_t            digits [NUM_DIGITS];
    logic                  unused_chain_top;

    assign ev_inc = inc_in & ~inc_q;
    assign ev_dec = dec_in & ~dec_q;

    // Clear wins, simultaneous edges cancel, saturation blocks the chain at the ends.
    assign carry[0]  = ev_inc & ~ev_dec & ~clr_in & ~all9;
    assign borrow[0] = ev_dec & ~ev_inc & ~clr_in & ~all0;
    assign ovf_set   = ev_inc & ~ev_dec & ~clr_in & all9;

    // Saturation keeps the final carry/borrow at zero.
    assign unused_chain_top = carry[NUM_DIGITS] | borrow[NUM_DIGITS];

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_cell u_cell (
            .CLK_50M  (CLK_50M),
            .RST      (RST),
            .inc_ci   (carry[i]),
            .dec_bi   (borrow[i]),
            .clr      (clr_in),
            .digit    (digits[i]),
            .carry_o  (carry[i+1]),
            .borrow_o (borrow[i+1])
        );
        assign score_o[4*i +: 4] = digits[i];
    end

    always_comb begin
        all9 = 1'b1;
        all0 = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            all9 = all9 & (digits[i] == 4'd9);
            all0 = all0 & (digits[i] == 4'd0);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; digit 0 is always shown.
    always_comb begin
        logic nz_seen;
        nz_seen = 1'b0;
        shown   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz_seen  = nz_seen | (digits[i] != 4'd0);
            shown[i] = nz_seen | (i == 0);
        end
    end
`else
    assign shown = '1;
`endif

    // Edge registers, overflow flag and the scan; sel/seg load together at each index change.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            inc_q   <= 1'b1;
            dec_q   <= 1'b1;
            ovf_o   <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            sel     <= '1;
            seg_out <= SEG_BLANK;
        end else begin
            inc_q <= inc_in;
            dec_q <= dec_in;
            if (clr_in) begin
                ovf_o <= 1'b0;
            end else if (ovf_set) begin
                ovf_o <= 1'b1;
            end
            if (cnt == CNT_LAST) begin
                cnt     <= '0;
                sel     <= ~(NUM_DIGITS'(1) << idx);
                seg_out <= shown[idx] ? seg7_encode(digits[idx]) : SEG_BLANK;
                idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
